// File: rtl/aes_key_sync_source_if.sv
// dvr_key_if: key/sync offer channel (valid/rdy handshake carrying key and sync words)
interface dvr_key_if #(
   parameter int DATA_WIDTH_IN_BYTES = 16
);
   localparam int W = DATA_WIDTH_IN_BYTES * 8;
   logic         valid;
   logic         rdy;
   logic [W-1:0] key;
   logic [W-1:0] sync;
   modport master (output valid, output key, output sync, input rdy);
   modport slave  (input valid, input key, input sync, output rdy);
endinterface

// File: rtl/aes_key_sync_source.sv
// aes_key_sync_source: offers key/sync pairs once per message and tracks the encrypted stream
module aes_key_sync_source #(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   localparam int W = DATA_WIDTH_IN_BYTES * 8
) (
   input  logic         clk,
   input  logic         rst,
   dvr_key_if.master    key_and_sync,
   input  logic [W-1:0] cfg_key,
   input  logic         cfg_key_wr,
   input  logic [W-1:0] cfg_seed,
   input  logic         cfg_seed_wr,
   input  logic         enable,
   input  logic         msg_valid,
   input  logic         msg_rdy,
   input  logic         msg_eop,
   output logic [31:0]  offer_count,
   output logic         seq_error,
   output logic         sync_wrap
);
   typedef enum logic [1:0] {NO_KEY, IDLE, OFFER, IN_MSG} state_t;
   state_t       state_q, state_d;
   logic         valid_q, valid_d;
   logic [W-1:0] key_q, key_d, sync_q, sync_d;
   logic [W-1:0] key_sh_q, key_sh_d, seed_sh_q, seed_sh_d;
   logic         key_pend_q, key_pend_d, seed_pend_q, seed_pend_d;
   logic [31:0]  cnt_q, cnt_d;
   logic         seq_err_q, seq_err_d, wrap_q, wrap_d;
   logic         beat, accept, entry;
   // next-state, shadow/active register updates and status pulses
   always_comb begin
      beat = msg_valid & msg_rdy;
      accept = valid_q & key_and_sync.rdy;
      entry = (state_q == IDLE) & enable;
      state_d = state_q;
      case (state_q)
         NO_KEY:  state_d = cfg_key_wr ? IDLE : NO_KEY;
         IDLE:    state_d = enable ? OFFER : IDLE;
         OFFER:   state_d = accept ? IN_MSG : OFFER;
         IN_MSG:  state_d = (beat & msg_eop) ? IDLE : IN_MSG;
         default: state_d = NO_KEY;
      endcase
      valid_d = state_d == OFFER;
      key_sh_d = cfg_key_wr ? cfg_key : key_sh_q;
      seed_sh_d = cfg_seed_wr ? cfg_seed : seed_sh_q;
      key_pend_d = entry ? 1'b0 : (key_pend_q | cfg_key_wr);
      seed_pend_d = entry ? 1'b0 : (seed_pend_q | cfg_seed_wr);
      key_d = (entry & (key_pend_q | cfg_key_wr)) ? key_sh_d : key_q;
      sync_d = (entry & (seed_pend_q | cfg_seed_wr)) ? seed_sh_d :
               (accept & ~seed_pend_q) ? sync_q + W'(1) : sync_q;
      wrap_d = accept & ~seed_pend_q & (&sync_q);
      cnt_d = cnt_q + {31'b0, accept};
      seq_err_d = beat & (state_q != IN_MSG);
   end
   // state and data registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= NO_KEY;
         valid_q <= 1'b0;
         key_q <= '0;
         sync_q <= '0;
         key_sh_q <= '0;
         seed_sh_q <= '0;
         key_pend_q <= 1'b0;
         seed_pend_q <= 1'b0;
         cnt_q <= '0;
         seq_err_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         key_q <= key_d;
         sync_q <= sync_d;
         key_sh_q <= key_sh_d;
         seed_sh_q <= seed_sh_d;
         key_pend_q <= key_pend_d;
         seed_pend_q <= seed_pend_d;
         cnt_q <= cnt_d;
         seq_err_q <= seq_err_d;
         wrap_q <= wrap_d;
      end
   end
   assign key_and_sync.valid = valid_q;
   assign key_and_sync.key = key_q;
   assign key_and_sync.sync = sync_q;
   assign offer_count = cnt_q;
   assign seq_error = seq_err_q;
   assign sync_wrap = wrap_q;
endmodule

// File: tb/tb_aes_key_sync_source.sv
// tb_aes_key_sync_source: directed scenarios plus randomized offers checked against a transaction model
module tb_aes_key_sync_source;
   localparam int NB = 16;
   localparam int W = NB * 8;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [W-1:0] cfg_key = '0, cfg_seed = '0;
   logic cfg_key_wr = 1'b0, cfg_seed_wr = 1'b0, enable = 1'b0;
   logic msg_valid = 1'b0, msg_rdy = 1'b0, msg_eop = 1'b0;
   logic [31:0] offer_count;
   logic seq_error, sync_wrap;
   int checks = 0;
   int failures = 0;
   logic [W-1:0] lat_key, lat_seed, exp_key, exp_sync, base_sync;
   logic [W-1:0] k0, k1, ones;
   bit seed_since;
   logic [31:0] exp_count;

   dvr_key_if #(.DATA_WIDTH_IN_BYTES(NB)) ks ();

   aes_key_sync_source #(.DATA_WIDTH_IN_BYTES(NB)) dut (
      .clk(clk), .rst(rst), .key_and_sync(ks),
      .cfg_key(cfg_key), .cfg_key_wr(cfg_key_wr),
      .cfg_seed(cfg_seed), .cfg_seed_wr(cfg_seed_wr),
      .enable(enable), .msg_valid(msg_valid), .msg_rdy(msg_rdy), .msg_eop(msg_eop),
      .offer_count(offer_count), .seq_error(seq_error), .sync_wrap(sync_wrap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_w(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_c(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // random config writes; the model remembers the latest values and whether a seed arrived
   task automatic rand_cfg();
      cfg_key_wr = ($urandom_range(0, 3) == 0);
      cfg_seed_wr = ($urandom_range(0, 3) == 0);
      if (cfg_key_wr) begin
         cfg_key = rnd();
         lat_key = cfg_key;
      end
      if (cfg_seed_wr) begin
         cfg_seed = rnd();
         lat_seed = cfg_seed;
         seed_since = 1'b1;
      end
   endtask

   // an offer carries the newest key and either the newest unused seed or previous sync + 1
   task automatic model_entry();
      exp_key = lat_key;
      exp_sync = seed_since ? lat_seed : base_sync;
      seed_since = 1'b0;
      base_sync = exp_sync + W'(1);
   endtask

   initial begin
      k0 = 128'h000102030405060708090a0b0c0d0e0f;
      k1 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      ones = '1;
      ks.rdy = 1'b0;
      tick();
      tick();
      chk_b("rst_valid", ks.valid, 1'b0);
      chk_w("rst_key", ks.key, '0);
      chk_w("rst_sync", ks.sync, '0);
      chk_c("rst_count", offer_count, 32'd0);
      chk_b("rst_seq", seq_error, 1'b0);
      chk_b("rst_wrap", sync_wrap, 1'b0);
      rst = 1'b1;
      cfg_key = k0; cfg_key_wr = 1'b1; cfg_seed = '0; cfg_seed_wr = 1'b1; enable = 1'b1; ks.rdy = 1'b1;
      tick();
      cfg_key_wr = 1'b0; cfg_seed_wr = 1'b0;
      chk_b("first_wait", ks.valid, 1'b0);
      tick();
      chk_b("first_valid", ks.valid, 1'b1);
      chk_w("first_key", ks.key, k0);
      chk_w("first_sync", ks.sync, '0);
      tick();
      chk_c("first_count", offer_count, 32'd1);
      chk_b("first_drop", ks.valid, 1'b0);
      ks.rdy = 1'b0;
      msg_valid = 1'b1; msg_rdy = 1'b1;
      tick();
      tick();
      chk_b("msg_novalid", ks.valid, 1'b0);
      chk_b("msg_noseq", seq_error, 1'b0);
      msg_eop = 1'b1;
      tick();
      msg_valid = 1'b0; msg_rdy = 1'b0; msg_eop = 1'b0;
      chk_b("eop_n1", ks.valid, 1'b0);
      tick();
      chk_b("eop_n2", ks.valid, 1'b1);
      chk_w("second_sync", ks.sync, W'(1));
      chk_w("second_key", ks.key, k0);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cfg_key_wr = (i == 4);
         cfg_key = k1;
         cfg_seed_wr = (i == 6);
         cfg_seed = ones;
         tick();
         chk_b("stall_valid", ks.valid, 1'b1);
         chk_w("stall_key", ks.key, k0);
      end
      cfg_key_wr = 1'b0; cfg_seed_wr = 1'b0; enable = 1'b1; ks.rdy = 1'b1;
      tick();
      ks.rdy = 1'b0;
      chk_c("second_count", offer_count, 32'd2);
      chk_b("seed_pend_nowrap", sync_wrap, 1'b0);
      msg_valid = 1'b1; msg_rdy = 1'b1; msg_eop = 1'b1;
      tick();
      msg_valid = 1'b0; msg_rdy = 1'b0; msg_eop = 1'b0;
      tick();
      chk_w("new_key", ks.key, k1);
      chk_w("seed_ones", ks.sync, ones);
      ks.rdy = 1'b1;
      tick();
      ks.rdy = 1'b0;
      chk_b("wrap_pulse", sync_wrap, 1'b1);
      chk_w("wrap_sync", ks.sync, '0);
      chk_c("third_count", offer_count, 32'd3);
      msg_valid = 1'b1; msg_rdy = 1'b1; msg_eop = 1'b1;
      tick();
      msg_valid = 1'b0; msg_rdy = 1'b0; msg_eop = 1'b0;
      chk_b("wrap_once", sync_wrap, 1'b0);
      tick();
      chk_b("fourth_valid", ks.valid, 1'b1);
      chk_w("fourth_sync", ks.sync, '0);
      ks.rdy = 1'b1; msg_valid = 1'b1; msg_rdy = 1'b1; msg_eop = 1'b1;
      tick();
      ks.rdy = 1'b0; msg_valid = 1'b0; msg_rdy = 1'b0; msg_eop = 1'b0;
      chk_b("eop_accept_seq", seq_error, 1'b1);
      chk_c("eop_accept_count", offer_count, 32'd4);
      tick();
      chk_b("eop_ignored1", ks.valid, 1'b0);
      chk_b("seq_oneshot", seq_error, 1'b0);
      tick();
      chk_b("eop_ignored2", ks.valid, 1'b0);
      msg_valid = 1'b1; msg_rdy = 1'b1; msg_eop = 1'b1;
      tick();
      enable = 1'b0; msg_eop = 1'b0;
      tick();
      msg_valid = 1'b0; msg_rdy = 1'b0;
      chk_b("idle_beat_seq", seq_error, 1'b1);
      chk_b("idle_beat_valid", ks.valid, 1'b0);
      chk_c("idle_beat_count", offer_count, 32'd4);
      tick();
      chk_b("idle_seq_clear", seq_error, 1'b0);
      enable = 1'b1;
      tick();
      chk_b("idle_kept", ks.valid, 1'b1);
      chk_w("idle_kept_sync", ks.sync, W'(1));
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk_b("abort_valid", ks.valid, 1'b0);
      chk_c("abort_count", offer_count, 32'd0);
      chk_w("abort_key", ks.key, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_b("nokey_hold", ks.valid, 1'b0);
      end
      seed_since = 1'b0;
      base_sync = '0;
      exp_count = '0;
      enable = 1'b0;
      cfg_key = rnd();
      lat_key = cfg_key;
      lat_seed = '0;
      cfg_key_wr = 1'b1;
      tick();
      cfg_key_wr = 1'b0;
      for (int n = 0; n < 20; n++) begin
         enable = 1'b1;
         rand_cfg();
         tick();
         model_entry();
         chk_b("rnd_valid", ks.valid, 1'b1);
         chk_w("rnd_key", ks.key, exp_key);
         chk_w("rnd_sync", ks.sync, exp_sync);
         for (int h = $urandom_range(0, 4); h > 0; h--) begin
            enable = 1'($urandom_range(0, 1));
            rand_cfg();
            tick();
            chk_b("rnd_hold_valid", ks.valid, 1'b1);
            chk_w("rnd_hold_key", ks.key, exp_key);
            chk_w("rnd_hold_sync", ks.sync, exp_sync);
         end
         ks.rdy = 1'b1;
         rand_cfg();
         tick();
         ks.rdy = 1'b0;
         exp_count = exp_count + 32'd1;
         chk_b("rnd_accept_drop", ks.valid, 1'b0);
         chk_c("rnd_count", offer_count, exp_count);
         chk_b("rnd_nowrap", sync_wrap, 1'b0);
         for (int b = $urandom_range(0, 3); b > 0; b--) begin
            msg_valid = 1'($urandom_range(0, 1));
            msg_rdy = 1'($urandom_range(0, 1));
            rand_cfg();
            tick();
            chk_b("rnd_msg_valid", ks.valid, 1'b0);
            chk_b("rnd_msg_seq", seq_error, 1'b0);
         end
         msg_valid = 1'b1; msg_rdy = 1'b1; msg_eop = 1'b1;
         rand_cfg();
         tick();
         msg_valid = 1'b0; msg_rdy = 1'b0; msg_eop = 1'b0;
         chk_b("rnd_eop_valid", ks.valid, 1'b0);
      end
      cfg_key_wr = 1'b0; cfg_seed_wr = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
